// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional NIBBLE_SERIAL_ADDER_OVF_EN adds a signed-overflow output to the top.
package nibble_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bus of the nibble-serial adder.
// Optional NIBBLE_SERIAL_ADDER_OVF_EN adds the ovf result bit.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    // Both sides: a transfer happens on a rising edge where valid && ready;
    // ready/valid from the adder depend on its state only, never on the peer.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/nibble_serial_adder_fourbit.sv
// The shared combinational 4-bit ripple-carry adder reused for every nibble.
module fourbitAdder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that feeds one nibble per clock through a single fourbitAdder.
// Optional NIBBLE_SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_adder_if.slave bus,
    output state_t               state_dbg
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
        $fatal(1, "nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             state;
    state_t             state_next;
    logic               in_ready;
    logic               out_valid;
    logic [CNT_W-1:0]   cnt;
    logic               last_nib;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic [WIDTH-1:0]   sum_next;
    logic               carry_reg;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic [NIB_W-1:0]   fa_sum;
    logic               fa_cout;

    fourbitAdder u_fa (
        .a    (a_sh[NIB_W-1:0]),
        .b    (b_sh[NIB_W-1:0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_nib = (cnt == CNT_W'(NIB - 1));
    // The fresh nibble enters at the top so after NIB shifts nibble 0 sits at the bottom.
    assign sum_next = WIDTH'({fa_sum, sum_sh} >> NIB_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry_reg <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh      <= bus.a;
                        b_sh      <= bus.b;
                        carry_reg <= bus.cin;
                        cnt       <= '0;
                    end
                end
                ADD: begin
                    a_sh      <= a_sh >> NIB_W;
                    b_sh      <= b_sh >> NIB_W;
                    sum_sh    <= sum_next;
                    carry_reg <= fa_cout;
                    cnt       <= cnt + CNT_W'(1);
                    // Visible result only changes when an operation completes.
                    if (last_nib) begin
                        sum_q  <= sum_next;
                        cout_q <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == ADD && last_nib) begin
            ovf_q <= (a_sh[NIB_W-1] == b_sh[NIB_W-1]) && (fa_sum[NIB_W-1] != a_sh[NIB_W-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign state_dbg     = state;

endmodule
